// File: rtl/spi_txn_sched.sv
// rtl/spi_txn_sched.sv - two-requester round-robin scheduler feeding an SPI transmit engine
module spi_txn_sched #(
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 4
) (
  input  logic       m_clk,
  input  logic       n_reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_data,
  output logic       eng_start,
  input  logic       eng_done,
  output logic       busy,
  output logic       gnt_id,
  output logic       txn_done,
  output logic       txn_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GMAX = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAPW
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          win;
  logic          wait_exit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_start  = 1'b0;
    win        = 1'b0;
    wait_exit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Grants are suppressed while reset is held so no transfer is lost.
        if (!n_reset && (req0_valid || req1_valid)) begin
          win        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          req0_ready = ~win;
          req1_ready = win;
          addr_d     = win ? req1_addr : req0_addr;
          data_d     = win ? req1_data : req0_data;
          gnt_d      = win;
          last_d     = win;
          state_d    = S_START;
        end
      end
      S_START: begin
        eng_start = ~n_reset;
        tcnt_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // Completion takes priority over a coincident timeout.
        if (eng_done) begin
          done_d    = 1'b1;
          wait_exit = 1'b1;
        end else if (tcnt_q == TMAX) begin
          err_d     = 1'b1;
          wait_exit = 1'b1;
        end
        if (wait_exit) begin
          gcnt_d  = '0;
          state_d = (GAP == 0) ? S_IDLE : S_GAPW;
        end
      end
      S_GAPW: begin
        if (gcnt_q == GMAX) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (n_reset) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign eng_addr = addr_q;
  assign eng_data = data_q;
  assign gnt_id   = gnt_q;
  assign txn_done = done_q;
  assign txn_err  = err_q;

endmodule

// File: tb/tb_spi_txn_sched.sv
// tb/tb_spi_txn_sched.sv - randomized bench for spi_txn_sched against a timestamp-based reference model
module tb_spi_txn_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1, done;
  logic [7:0] a0, d0, a1, d1;

  logic [1:0]      o_r0, o_r1, o_st, o_busy, o_gid, o_dn, o_er;
  logic [1:0][7:0] o_ea, o_ed;

  spi_txn_sched #(.TIMEOUT(40), .GAP(4)) u_a (
    .m_clk(clk), .n_reset(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_addr(a0), .req1_addr(a1), .req0_data(d0), .req1_data(d1),
    .req0_ready(o_r0[0]), .req1_ready(o_r1[0]),
    .eng_addr(o_ea[0]), .eng_data(o_ed[0]), .eng_start(o_st[0]), .eng_done(done),
    .busy(o_busy[0]), .gnt_id(o_gid[0]), .txn_done(o_dn[0]), .txn_err(o_er[0])
  );

  spi_txn_sched #(.TIMEOUT(8), .GAP(0)) u_b (
    .m_clk(clk), .n_reset(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_addr(a0), .req1_addr(a1), .req0_data(d0), .req1_data(d1),
    .req0_ready(o_r0[1]), .req1_ready(o_r1[1]),
    .eng_addr(o_ea[1]), .eng_data(o_ed[1]), .eng_start(o_st[1]), .eng_done(done),
    .busy(o_busy[1]), .gnt_id(o_gid[1]), .txn_done(o_dn[1]), .txn_err(o_er[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Transaction-level model: each instance tracks its grant cycle and when it resolves.
  bit         m_in[2], m_res[2], m_last[2], m_kind[2], m_gid[2];
  int         m_g[2], m_idle_c[2], m_pulse_c[2];
  logic [7:0] m_ea[2], m_ed[2];

  int         n_done[2], n_err[2];
  int         st_gnt0[$], st_gnt1[$], st_cyc1[$];
  logic [7:0] st_addr0[$], st_dat0[$];

  function automatic int to_of(input int k);
    return (k == 0) ? 40 : 8;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic string tg(input int k, input string s);
    return {(k == 0) ? "a." : "b.", s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    m_in[k]      = 1'b0;
    m_res[k]     = 1'b0;
    m_last[k]    = 1'b1;
    m_ea[k]      = 8'h00;
    m_ed[k]      = 8'h00;
    m_gid[k]     = 1'b0;
    m_pulse_c[k] = -10;
  endtask

  task automatic step_one(input int k);
    bit idle, grant, w;
    int c;
    c     = cyc;
    idle  = !m_in[k] || (m_res[k] && c >= m_idle_c[k]);
    w     = (v0 && v1) ? !m_last[k] : v1;
    grant = idle && !rst && (v0 || v1);

    check(tg(k, "req0_ready"), o_r0[k], grant && !w);
    check(tg(k, "req1_ready"), o_r1[k], grant && w);
    check(tg(k, "eng_start"), o_st[k], m_in[k] && c == m_g[k] + 1 && !rst);
    check(tg(k, "busy"), o_busy[k], !idle);
    check(tg(k, "eng_addr"), o_ea[k], m_ea[k]);
    check(tg(k, "eng_data"), o_ed[k], m_ed[k]);
    check(tg(k, "gnt_id"), o_gid[k], m_gid[k]);
    check(tg(k, "txn_done"), o_dn[k], c == m_pulse_c[k] && m_kind[k]);
    check(tg(k, "txn_err"), o_er[k], c == m_pulse_c[k] && !m_kind[k]);

    if (o_st[k]) begin
      if (k == 0) begin
        st_gnt0.push_back(int'(o_gid[0]));
        st_addr0.push_back(o_ea[0]);
        st_dat0.push_back(o_ed[0]);
      end else begin
        st_gnt1.push_back(int'(o_gid[1]));
        st_cyc1.push_back(c);
      end
    end
    if (o_dn[k]) n_done[k]++;
    if (o_er[k]) n_err[k]++;

    if (rst) begin
      model_reset(k);
    end else begin
      if (m_in[k] && !m_res[k] && c >= m_g[k] + 2) begin
        if (done || c == m_g[k] + 1 + to_of(k)) begin
          m_res[k]     = 1'b1;
          m_kind[k]    = done;
          m_pulse_c[k] = c + 1;
          m_idle_c[k]  = c + 1 + gap_of(k);
        end
      end
      if (grant) begin
        m_in[k]   = 1'b1;
        m_res[k]  = 1'b0;
        m_g[k]    = c;
        m_ea[k]   = w ? a1 : a0;
        m_ed[k]   = w ? d1 : d0;
        m_gid[k]  = w;
        m_last[k] = w;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_one(0);
      step_one(1);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int sd0, sd1, se0, se1, base, base1;

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; done = 1'b0;
    a0 = 8'h00; d0 = 8'h00; a1 = 8'h00; d1 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      n_done[k] = 0;
      n_err[k]  = 0;
      m_g[k]    = -10;
      m_kind[k] = 1'b0;
      m_idle_c[k] = 0;
    end
    @(posedge clk);
    #1;
    cyc = 0;
    rst = 1'b0;
    check("reset.busy_a", o_busy[0], 0);
    check("reset.addr_b", o_ea[1], 0);
    tick(2);

    // Single request, completion 30 cycles after start; b times out meanwhile.
    sd0 = n_done[0]; se1 = n_err[1]; sd1 = n_done[1]; base = st_addr0.size();
    v0 = 1'b1; a0 = 8'd45; d0 = 8'd2;
    tick(1);
    v0 = 1'b0;
    tick(30);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(10);
    check("A.a_done", n_done[0] - sd0, 1);
    check("A.b_err", n_err[1] - se1, 1);
    check("A.b_done", n_done[1] - sd1, 0);
    check("A.addr", st_addr0[base], 45);
    check("A.data", st_dat0[base], 2);

    // Contention: both requesters continuously valid.
    do_reset();
    base = st_gnt0.size(); base1 = st_gnt1.size();
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a0 = 8'($urandom); d0 = 8'($urandom);
      a1 = 8'($urandom); d1 = 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0; done = 1'b0;
    tick(60);
    check("B.a_count", (st_gnt0.size() - base) >= 4, 1);
    check("B.b_count", (st_gnt1.size() - base1) >= 4, 1);
    for (int i = base; i < st_gnt0.size(); i++) check("B.a_alt", st_gnt0[i], (i - base) % 2);
    for (int i = base1; i < st_gnt1.size(); i++) check("B.b_alt", st_gnt1[i], (i - base1) % 2);

    // Done on the final timeout cycle of b; single req1 wins despite last_grant.
    do_reset();
    sd1 = n_done[1]; se1 = n_err[1];
    v1 = 1'b1; a1 = 8'h5a; d1 = 8'hc3;
    tick(1);
    v1 = 1'b0;
    tick(8);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(6);
    check("C.b_done", n_done[1] - sd1, 1);
    check("C.b_err", n_err[1] - se1, 0);
    check("C.b_gnt", st_gnt1[st_gnt1.size() - 1], 1);

    // GAP=0 back-to-back: done one cycle after each start.
    do_reset();
    base1 = st_cyc1.size();
    v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a1 = 8'($urandom); d1 = 8'($urandom);
      tick(2);
      done = 1'b1;
      tick(1);
      done = 1'b0;
    end
    v1 = 1'b0;
    tick(60);
    check("D.count", st_cyc1.size() - base1, 6);
    for (int i = base1 + 1; i < st_cyc1.size(); i++) check("D.spacing", st_cyc1[i] - st_cyc1[i-1], 3);

    // Reset in the middle of WAIT abandons the transaction silently.
    do_reset();
    sd0 = n_done[0]; se0 = n_err[0]; sd1 = n_done[1]; se1 = n_err[1];
    v0 = 1'b1; a0 = 8'h77; d0 = 8'h11;
    tick(1);
    v0 = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("E.busy_a", o_busy[0], 0);
    check("E.busy_b", o_busy[1], 0);
    check("E.addr_a", o_ea[0], 0);
    check("E.gnt_b", o_gid[1], 0);
    tick(12);
    check("E.pulses", (n_done[0] - sd0) + (n_err[0] - se0) + (n_done[1] - sd1) + (n_err[1] - se1), 0);
    v0 = 1'b1; v1 = 1'b1;
    tick(1);
    v0 = 1'b0; v1 = 1'b0;
    tick(2);
    check("E.a_next", st_gnt0[st_gnt0.size() - 1], 0);
    check("E.b_next", st_gnt1[st_gnt1.size() - 1], 0);
    tick(60);

    // Free-running random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      v0   = ($urandom_range(0, 2) == 0);
      v1   = ($urandom_range(0, 2) == 0);
      a0   = 8'($urandom); d0 = 8'($urandom);
      a1   = 8'($urandom); d1 = 8'($urandom);
      done = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; done = 1'b0;
    tick(60);
    check("F.idle_a", o_busy[0], 0);
    check("F.idle_b", o_busy[1], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
